// File: rtl/issue_sched.sv
// issue_sched: dual-lane in-order issue with a countdown scoreboard and split-issue FSM.
// Optional stall-cycle counter port/logic built only when PERF_CNT_EN is defined.
module issue_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [2:0] id_rm_1,
  input  logic [2:0] id_rn_1,
  input  logic [2:0] id_rd_1,
  input  logic       id_we_1,
  input  logic       id_mul_1,
  input  logic [2:0] id_rm_2,
  input  logic [2:0] id_rn_2,
  input  logic [2:0] id_rd_2,
  input  logic       id_ld_2,
  input  logic       id_st_2,
  input  logic       ex_flush,
  output logic       issue_1,
  output logic       issue_2,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       stall
`ifdef PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  typedef enum logic {ISSUE, SPLIT} state_t;

  state_t     r_state, w_next;
  logic [1:0] r_cnt [8];
  logic [7:0] w_busy;
  logic       w_h1, w_h2, w_dep, w_i1, w_i2, w_adv;

  // Register 0 is hardwired, so its busy bit stays clear.
  always_comb begin
    w_busy = '0;
    for (int k = 1; k < 8; k++) w_busy[k] = r_cnt[k] != 2'd0;
  end

  assign w_h1  = w_busy[id_rm_1] | w_busy[id_rn_1];
  assign w_h2  = w_busy[id_rm_2] | w_busy[id_rn_2] | (id_st_2 & w_busy[id_rd_2]);
  assign w_dep = id_we_1 && id_rd_1 != 3'd0 &&
                 (id_rm_2 == id_rd_1 || id_rn_2 == id_rd_1 ||
                  ((id_st_2 || id_ld_2) && id_rd_2 == id_rd_1));

  always_comb begin
    w_next = r_state;
    w_i1   = 1'b0;
    w_i2   = 1'b0;
    w_adv  = 1'b0;
    if (ex_flush) begin
      w_adv  = 1'b1;
      w_next = ISSUE;
    end else if (r_state == SPLIT) begin
      if (!w_h2) begin
        w_i2   = 1'b1;
        w_adv  = 1'b1;
        w_next = ISSUE;
      end
    end else if (!id_valid) begin
      w_adv = 1'b1;
    end else if (!w_h1) begin
      w_i1 = 1'b1;
      if (w_h2 || w_dep) w_next = SPLIT;
      else begin
        w_i2  = 1'b1;
        w_adv = 1'b1;
      end
    end
  end

  assign issue_1  = rst_n & w_i1;
  assign issue_2  = rst_n & w_i2;
  assign pc_we    = rst_n & w_adv;
  assign if_id_we = pc_we;
  assign stall    = ~pc_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ISSUE;
    else r_state <= w_next;
  end

  // Countdown first, then a newly issued producer overrides its destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) r_cnt[k] <= 2'd0;
    end else begin
      for (int k = 0; k < 8; k++) r_cnt[k] <= (r_cnt[k] != 2'd0) ? r_cnt[k] - 2'd1 : 2'd0;
      if (issue_1 && id_mul_1 && id_we_1 && id_rd_1 != 3'd0) r_cnt[id_rd_1] <= 2'd2;
      if (issue_2 && id_ld_2 && id_rd_2 != 3'd0) r_cnt[id_rd_2] <= 2'd1;
    end
  end

`ifdef PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall_cnt <= '0;
    else if (stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign stall_cnt = r_stall_cnt;
`endif
endmodule
